alu_multibyte_seq: RTL and testbench
====================================

# alu_multibyte_seq

Multi-byte arithmetic/logic sequencer. It sits between the control unit and the 8-bit ALU and drives the ALU's operand, carry-in and opcode inputs one byte lane at a time, LSB first. It captures the ALU's registered result and flags after each lane and chains carry/borrow between lanes, so the CPU gets up to MAX_BYTES-wide ADD/SUB/logic operations with aggregated flags. It is the initiator side of the ALU interface.

## Interface
- DATA_WIDTH, 8, ALU lane width; must match the ALU.
- MAX_BYTES, 4, maximum lanes per operation.
- NB_W, $clog2(MAX_BYTES)+1, width of num_bytes.

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 INV, 6/7 reserved
- num_bytes  in  NB_W  lanes to process
- operand_a  in  DATA_WIDTH*MAX_BYTES  first operand; lane 0 is bits [7:0]
- operand_b  in  DATA_WIDTH*MAX_BYTES  second operand (ignored for INV)
- busy  out  1  high from start acceptance until the done cycle inclusive
- done  out  1  one-cycle pulse; result and flags valid from this cycle
- result  out  DATA_WIDTH*MAX_BYTES  assembled result
- carry_out  out  1  carry of the last lane (1 = no borrow for SUB)
- zero_out  out  1  whole active result == 0
- negative_out  out  1  MSB of the last active lane
- alu_in_one, alu_in_two  out  DATA_WIDTH  ALU operands
- alu_in_carry  out  1  ALU carry-in
- alu_op  out  4  ALU opcode (arch_defs_pkg ALU_* constants)
- alu_result  in  DATA_WIDTH  ALU latched_result
- alu_zero, alu_carry, alu_negative  in  1  ALU registered flags

## Operation
- States: IDLE, ISSUE, CAPTURE, DONE.
- IDLE & start → ISSUE.
  - Latch operand_a, operand_b and op.
  - Latch n = clamp(num_bytes): 0 → 1, >MAX_BYTES → MAX_BYTES.
  - Set lane = 0, clear the result register, set zero_acc = 1.
- start in any other state is ignored.
- ISSUE drives lane `lane` onto the ALU:
  - alu_in_one = A[lane], alu_in_two = B[lane].
  - Opcode mapping:
    - ADD: lane 0 ALU_ADD, otherwise ALU_ADC.
    - SUB: lane 0 ALU_SUB, otherwise ALU_SBC.
    - AND, OR, XOR, INV map to ALU_AND, ALU_OR, ALU_XOR, ALU_INV.
    - Reserved opcodes execute as ALU_AND with alu_in_two forced to 0.
  - alu_in_carry = carry_reg (carry captured from the previous lane); 0 for lane 0.
  - Next state: CAPTURE.
- CAPTURE:
  - result[lane] ← alu_result; carry_reg ← alu_carry; zero_acc ← zero_acc & alu_zero.
  - If lane == n-1, also capture neg_reg ← alu_negative.
  - If lane == n-1 → DONE; else lane+1 → ISSUE.
- DONE:
  - done = 1.
  - carry_out/zero_out/negative_out ← carry_reg/zero_acc/neg_reg.
  - Next state: IDLE.
- Lanes at or above n read 0 in result.
- Logic ops yield carry_out = 0, because the ALU reports carry 0 for them.
- Outputs hold their values until the next accepted start.
- Outside ISSUE the ALU inputs are parked: alu_op = ALU_ADD, operands 0, alu_in_carry 0. The ALU updates every cycle, so alu_result is only consumed in CAPTURE.

## Timing
- Reset values:
  - State IDLE, busy 0, done 0, result 0, carry_out 0, zero_out 1, negative_out 0.
  - Parked ALU drive, lane 0, carry_reg 0.
- Start is accepted at edge E0. busy is high from the cycle after E0.
- Each lane takes 2 cycles: ISSUE drives the ALU combinationally, the ALU registers at the next edge, and CAPTURE reads it.
- done asserts in cycle 2n+1 after E0; busy is high for 2n+1 cycles.
  - n=1: done in cycle 3; n=4: done in cycle 9.
- The next start is accepted in the cycle after done, when the sequencer is back in IDLE.
- Reset mid-operation (any state):
  - Next cycle: all reset values.
  - No done pulse; the partial result is discarded.
  - The ALU resets on the same reset.
- start held high continuously produces back-to-back operations, one every 2n+2 cycles.

## Test plan
- ADD n=4, A=0x000000FF, B=0x00000001 → result 0x00000100, carry 0, zero 0, neg 0; done in cycle 9; ALU sees ALU_ADD then 3× ALU_ADC.
- ADD n=4, A=0xFFFFFFFF, B=0x00000001 → result 0x00000000, carry 1, zero 1, neg 0.
- SUB n=2, A=0x0000, B=0x0001 → result 0x0000FFFF, carry 0 (borrow), neg 1, zero 0. SUB n=2, A=0x1234, B=0x0234 → 0x1000, carry 1.
- XOR n=3, A=B=0x00A5A5A5 → result 0, zero 1, carry 0. INV n=1, A=0x0F → 0x000000F0, neg 1, zero 0.
- num_bytes=0 → one lane, done in cycle 3. num_bytes=7 → four lanes, done in cycle 9. Reserved op=6 → result 0, zero 1.
- Robustness: start pulsed during busy → no effect. Reset asserted in the lane-2 ISSUE of an n=4 ADD → next cycle busy 0, result 0, zero_out 1, no done. A fresh start then completes correctly.

Source files
------------

// File: rtl/alu_multibyte_seq_if.sv
// ALU lane bus between the multi-byte sequencer (master)
// and the 8-bit ALU (slave).
interface alu_multibyte_seq_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] alu_in_one;
    logic [DATA_WIDTH-1:0] alu_in_two;
    logic                  alu_in_carry;
    logic [3:0]            alu_op;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_zero;
    logic                  alu_carry;
    logic                  alu_negative;

    modport master (
        output alu_in_one,
        output alu_in_two,
        output alu_in_carry,
        output alu_op,
        input  alu_result,
        input  alu_zero,
        input  alu_carry,
        input  alu_negative
    );

    modport slave (
        input  alu_in_one,
        input  alu_in_two,
        input  alu_in_carry,
        input  alu_op,
        output alu_result,
        output alu_zero,
        output alu_carry,
        output alu_negative
    );
endinterface

// File: rtl/alu_multibyte_seq.sv
// Multi-byte ALU sequencer: feeds the 8-bit ALU one lane at a time,
// LSB first, chaining carry/borrow and aggregating the flags.
module alu_multibyte_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BYTES  = 4,
    parameter int NB_W       = $clog2(MAX_BYTES) + 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [2:0]                      op,
    input  logic [NB_W-1:0]                 num_bytes,
    input  logic [DATA_WIDTH*MAX_BYTES-1:0] operand_a,
    input  logic [DATA_WIDTH*MAX_BYTES-1:0] operand_b,
    output logic                            busy,
    output logic                            done,
    output logic [DATA_WIDTH*MAX_BYTES-1:0] result,
    output logic                            carry_out,
    output logic                            zero_out,
    output logic                            negative_out,
    alu_multibyte_seq_if.master             bus
);
    localparam int W  = DATA_WIDTH * MAX_BYTES;
    localparam int LW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

    // ALU opcode encoding; must track the ALU's decode table
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_ADC = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_SBC = 4'd3;
    localparam logic [3:0] ALU_AND = 4'd4;
    localparam logic [3:0] ALU_OR  = 4'd5;
    localparam logic [3:0] ALU_XOR = 4'd6;
    localparam logic [3:0] ALU_INV = 4'd7;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_INV = 3'd5;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    state_t        state;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [2:0]    op_reg;
    logic [LW-1:0] lane;
    logic [LW-1:0] last;
    logic          zero_acc;

    function automatic logic [DATA_WIDTH-1:0] lane_of(
        input logic [W-1:0] v,
        input int           idx
    );
        return v[idx*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    function automatic logic [3:0] alu_code(
        input logic [2:0] o,
        input logic       first
    );
        case (o)
            OP_ADD:  return first ? ALU_ADD : ALU_ADC;
            OP_SUB:  return first ? ALU_SUB : ALU_SBC;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_XOR:  return ALU_XOR;
            OP_INV:  return ALU_INV;
            default: return ALU_AND;
        endcase
    endfunction

    // Reserved opcodes run as AND with a zero operand -> result 0
    function automatic logic [DATA_WIDTH-1:0] op_two(
        input logic [2:0]            o,
        input logic [DATA_WIDTH-1:0] b
    );
        return (o > OP_INV) ? '0 : b;
    endfunction

    function automatic logic [LW-1:0] clamp_last(
        input logic [NB_W-1:0] nb
    );
        if (nb == '0) return '0;
        if (int'(nb) > MAX_BYTES) return LW'(MAX_BYTES - 1);
        return LW'(int'(nb) - 1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            result           <= '0;
            carry_out        <= 1'b0;
            zero_out         <= 1'b1;
            negative_out     <= 1'b0;
            a_reg            <= '0;
            b_reg            <= '0;
            op_reg           <= OP_ADD;
            lane             <= '0;
            last             <= '0;
            zero_acc         <= 1'b1;
            bus.alu_op       <= ALU_ADD;
            bus.alu_in_one   <= '0;
            bus.alu_in_two   <= '0;
            bus.alu_in_carry <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state            <= ISSUE;
                        busy             <= 1'b1;
                        a_reg            <= operand_a;
                        b_reg            <= operand_b;
                        op_reg           <= op;
                        last             <= clamp_last(num_bytes);
                        lane             <= '0;
                        result           <= '0;
                        zero_acc         <= 1'b1;
                        bus.alu_op       <= alu_code(op, 1'b1);
                        bus.alu_in_one   <= lane_of(operand_a, 0);
                        bus.alu_in_two   <= op_two(op, lane_of(operand_b, 0));
                        bus.alu_in_carry <= 1'b0;
                    end
                end
                ISSUE: begin
                    state            <= CAPTURE;
                    bus.alu_op       <= ALU_ADD;
                    bus.alu_in_one   <= '0;
                    bus.alu_in_two   <= '0;
                    bus.alu_in_carry <= 1'b0;
                end
                CAPTURE: begin
                    result[int'(lane)*DATA_WIDTH +: DATA_WIDTH] <= bus.alu_result;
                    zero_acc <= zero_acc & bus.alu_zero;
                    if (lane == last) begin
                        state        <= DONE;
                        done         <= 1'b1;
                        carry_out    <= bus.alu_carry;
                        zero_out     <= zero_acc & bus.alu_zero;
                        negative_out <= bus.alu_negative;
                    end else begin
                        // Next lane goes out with the carry just captured
                        state            <= ISSUE;
                        lane             <= lane + 1'b1;
                        bus.alu_op       <= alu_code(op_reg, 1'b0);
                        bus.alu_in_one   <= lane_of(a_reg, int'(lane) + 1);
                        bus.alu_in_two   <= op_two(op_reg,
                                              lane_of(b_reg, int'(lane) + 1));
                        bus.alu_in_carry <= bus.alu_carry;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_multibyte_seq.sv
// Bench for alu_multibyte_seq: behavioural 8-bit ALU plus a
// whole-word arithmetic reference for every operation.
module tb_alu_multibyte_seq;
    localparam logic [3:0] A_ADD = 4'd0;
    localparam logic [3:0] A_ADC = 4'd1;
    localparam logic [3:0] A_SUB = 4'd2;
    localparam logic [3:0] A_SBC = 4'd3;
    localparam logic [3:0] A_AND = 4'd4;
    localparam logic [3:0] A_OR  = 4'd5;
    localparam logic [3:0] A_XOR = 4'd6;
    localparam logic [3:0] A_INV = 4'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [2:0]  num_bytes = 3'd0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic [31:0] result;
    logic        busy, done, carry_out, zero_out, negative_out;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    alu_multibyte_seq_if #(.DATA_WIDTH(8)) bus ();

    alu_multibyte_seq #(
        .DATA_WIDTH(8), .MAX_BYTES(4), .NB_W(3)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .num_bytes(num_bytes), .operand_a(operand_a),
        .operand_b(operand_b), .busy(busy), .done(done),
        .result(result), .carry_out(carry_out),
        .zero_out(zero_out), .negative_out(negative_out),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // 8-bit ALU with registered result and flags
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum = '0;
        case (bus.alu_op)
            A_ADD: alu_sum = {1'b0, bus.alu_in_one} + {1'b0, bus.alu_in_two};
            A_ADC: alu_sum = {1'b0, bus.alu_in_one} + {1'b0, bus.alu_in_two}
                             + {8'd0, bus.alu_in_carry};
            A_SUB: alu_sum = {1'b0, bus.alu_in_one} + {1'b0, ~bus.alu_in_two}
                             + 9'd1;
            A_SBC: alu_sum = {1'b0, bus.alu_in_one} + {1'b0, ~bus.alu_in_two}
                             + {8'd0, bus.alu_in_carry};
            A_AND: alu_sum = {1'b0, bus.alu_in_one & bus.alu_in_two};
            A_OR:  alu_sum = {1'b0, bus.alu_in_one | bus.alu_in_two};
            A_XOR: alu_sum = {1'b0, bus.alu_in_one ^ bus.alu_in_two};
            A_INV: alu_sum = {1'b0, ~bus.alu_in_one};
            default: alu_sum = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.alu_result   <= '0;
            bus.alu_carry    <= 1'b0;
            bus.alu_zero     <= 1'b0;
            bus.alu_negative <= 1'b0;
        end else begin
            bus.alu_result   <= alu_sum[7:0];
            bus.alu_carry    <= alu_sum[8];
            bus.alu_zero     <= (alu_sum[7:0] == 8'd0);
            bus.alu_negative <= alu_sum[7];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp_n(input logic [2:0] nb);
        if (nb == 3'd0) return 1;
        if (nb > 3'd4) return 4;
        return int'(nb);
    endfunction

    // Reference: the whole n-byte word computed in one go
    function automatic void model(
        input  logic [2:0]  o,
        input  int          n,
        input  logic [31:0] a,
        input  logic [31:0] b,
        output logic [31:0] r,
        output logic        c,
        output logic        z,
        output logic        ng
    );
        logic [63:0] m, am, bm, s;
        m  = (64'd1 << (8 * n)) - 64'd1;
        am = {32'd0, a} & m;
        bm = {32'd0, b} & m;
        c  = 1'b0;
        case (o)
            3'd0: begin s = am + bm; c = s[8*n]; end
            3'd1: begin s = am + (~bm & m) + 64'd1; c = s[8*n]; end
            3'd2: s = am & bm;
            3'd3: s = am | bm;
            3'd4: s = am ^ bm;
            3'd5: s = ~am & m;
            default: s = 64'd0;
        endcase
        r  = 32'(s & m);
        z  = (r == 32'd0);
        ng = r[8*n-1];
    endfunction

    function automatic logic carry_into(input logic [31:0] a,
                                        input logic [31:0] b, input int l);
        logic [63:0] m, s;
        if (l == 0) return 1'b0;
        m = (64'd1 << (8 * l)) - 64'd1;
        s = ({32'd0, a} & m) + ({32'd0, b} & m);
        return s[8*l];
    endfunction

    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [2:0] nb, input logic [31:0] a,
                          input logic [31:0] b, input bit glitch,
                          input bit chk_ops);
        logic [31:0] er;
        logic        ec, ez, en;
        logic [20:0] exp_drv;
        int          n, dcyc, bcnt, l;
        n = clamp_n(nb);
        model(o, n, a, b, er, ec, ez, en);
        @(negedge clk);
        start = 1'b1; op = o; num_bytes = nb;
        operand_a = a; operand_b = b;
        @(posedge clk);
        dcyc = 0;
        bcnt = 0;
        for (int k = 1; k <= 20 && dcyc == 0; k++) begin
            @(negedge clk);
            if (!glitch && k == 1) start = 1'b0;
            if (glitch && k == 1) begin
                operand_a = ~a; op = 3'd4; num_bytes = 3'd1;
            end
            if (glitch && k == 4) start = 1'b0;
            if (busy) bcnt++;
            if (chk_ops && k <= 2 * n) begin
                l = (k - 1) / 2;
                if (k % 2 == 1)
                    exp_drv = {(l == 0) ? A_ADD : A_ADC, a[8*l +: 8],
                               b[8*l +: 8], carry_into(a, b, l)};
                else
                    exp_drv = {A_ADD, 8'd0, 8'd0, 1'b0};
                check($sformatf("%s.drive%0d", tag, k),
                      {43'd0, bus.alu_op, bus.alu_in_one,
                       bus.alu_in_two, bus.alu_in_carry},
                      {43'd0, exp_drv});
            end
            if (done) dcyc = k;
        end
        start = 1'b0;
        check({tag, ".done_cycle"}, 64'(dcyc), 64'(2 * n + 1));
        check({tag, ".busy_cycles"}, 64'(bcnt), 64'(2 * n + 1));
        check({tag, ".result"}, {32'd0, result}, {32'd0, er});
        check({tag, ".flags"}, {61'd0, carry_out, zero_out, negative_out},
              {61'd0, ec, ez, en});
        @(negedge clk);
        check({tag, ".after"}, {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst.ctl", {59'd0, busy, done, carry_out, zero_out,
              negative_out}, 64'b00010);
        check("rst.result", {32'd0, result}, 64'd0);
        check("rst.drive", {43'd0, bus.alu_op, bus.alu_in_one,
              bus.alu_in_two, bus.alu_in_carry}, 64'd0);

        run_op("add_ff", 3'd0, 3'd4, 32'h000000FF, 32'h00000001, 0, 1);
        run_op("add_wrap", 3'd0, 3'd4, 32'hFFFFFFFF, 32'h00000001, 0, 1);
        run_op("sub_borrow", 3'd1, 3'd2, 32'h00000000, 32'h00000001, 0, 0);
        run_op("sub_ok", 3'd1, 3'd2, 32'h00001234, 32'h00000234, 0, 0);
        run_op("xor_eq", 3'd4, 3'd3, 32'h00A5A5A5, 32'h00A5A5A5, 0, 0);
        run_op("inv1", 3'd5, 3'd1, 32'h0000000F, 32'h12345678, 0, 0);
        run_op("nb0", 3'd0, 3'd0, 32'hAABBCC80, 32'h11223380, 0, 0);
        run_op("nb7", 3'd0, 3'd7, 32'h89ABCDEF, 32'h76543211, 0, 0);
        run_op("rsvd6", 3'd6, 3'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        run_op("glitch", 3'd0, 3'd4, 32'h12345678, 32'h11111111, 1, 0);

        // Reset during the lane-2 ISSUE of a 4-byte ADD
        @(negedge clk);
        start = 1'b1; op = 3'd0; num_bytes = 3'd4;
        operand_a = 32'h01020304; operand_b = 32'h05060708;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        check("midrst.lane2", {43'd0, bus.alu_op, bus.alu_in_one,
              bus.alu_in_two, bus.alu_in_carry},
              {43'd0, A_ADC, 8'h02, 8'h06, 1'b0});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst.ctl", {59'd0, busy, done, carry_out, zero_out,
              negative_out}, 64'b00010);
        check("midrst.result", {32'd0, result}, 64'd0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("midrst.quiet", 64'(seen), 64'd0);
        run_op("fresh", 3'd1, 3'd4, 32'h80000000, 32'h00000001, 0, 0);

        for (int i = 0; i < 24; i++)
            run_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), $urandom, $urandom, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
